// File: rtl/inject_scheduler_pkg.sv
// Shared widths, payload types and state encoding for the node injection scheduler.
package inject_scheduler_pkg;

  localparam int unsigned FLIT_CHILD_WIDTH = 85;
  localparam int unsigned VALID_BIT_POS    = 81;
  localparam int unsigned NEW_COMM_WIDTH   = 61;
  localparam int unsigned lg_numprocs      = 4;
  localparam int unsigned DstWidth         = lg_numprocs;
  localparam int unsigned CommTableWidth   = 53;
  localparam int unsigned ContextIdWidth   = 8;
  localparam int unsigned SETTLE_W         = 3;

  typedef logic [FLIT_CHILD_WIDTH-1:0] flit_t;

  localparam flit_t FLIT_VALID_MASK = FLIT_CHILD_WIDTH'(1) << VALID_BIT_POS;

  // Comm-table install word as seen on the node newcomm input.
  typedef struct packed {
    logic [CommTableWidth-1:0] comm_table;
    logic [ContextIdWidth-1:0] context_id;
  } newcomm_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_CONFIG = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

endpackage

// File: rtl/inject_scheduler_if.sv
// Requester, node-injection and comm-install signals of the injection scheduler.
interface inject_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
);
  import inject_scheduler_pkg::*;

  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ*FLIT_CHILD_WIDTH-1:0] req_flit;
  logic [NUM_REQ-1:0]                  req_ready;
  flit_t                               inject_flit;
  logic                                credit_return;
  logic                                cfg_valid;
  newcomm_t                            cfg_data;
  logic                                cfg_ready;
  newcomm_t                            newcomm_out;
  logic                                busy;
  logic                                credit_err;

  modport master (
    output req_valid, req_flit, credit_return, cfg_valid, cfg_data,
    input  req_ready, inject_flit, cfg_ready, newcomm_out, busy, credit_err
  );

  modport slave (
    input  req_valid, req_flit, credit_return, cfg_valid, cfg_data,
    output req_ready, inject_flit, cfg_ready, newcomm_out, busy, credit_err
  );

endinterface

// File: rtl/inject_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] winner
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic        found;
  logic [31:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + 32'(k)) % NUM_REQ;
      if (!found && req[PTR_W'(idx)]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  assign grant = (en && found) ? (NUM_REQ'(1) << winner) : '0;

endmodule

// File: rtl/inject_scheduler.sv
// Shares one node injection port among NUM_REQ requesters with credit flow control,
// and quiesces/drains injection around each comm-table install.
module inject_scheduler
  import inject_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned CREDITS    = 4,
  parameter int unsigned CFG_SETTLE = 2
) (
  input logic               clk,
  input logic               rst,
  inject_scheduler_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] CREDITS_MAX = CNT_W'(CREDITS);

  state_t                state;
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      winner;
  logic [NUM_REQ-1:0]    grant;
  logic                  grant_en;
  logic                  grant_any;
  logic [CNT_W-1:0]      credits;
  logic [SETTLE_W-1:0]   settle;
  flit_t                 flits [NUM_REQ];
  flit_t                 inject_q;
  newcomm_t              newcomm_q;
  logic                  cfg_ready_q;
  logic                  busy_q;
  logic                  credit_err_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign flits[g] = bus.req_flit[g*FLIT_CHILD_WIDTH +: FLIT_CHILD_WIDTH];
  end

  // A pending install beats any same-cycle request; reset forces ready low.
  assign grant_en = !rst && (state == ST_RUN) && !bus.cfg_valid && (credits != '0);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (bus.req_valid),
    .ptr    (ptr),
    .en     (grant_en),
    .grant  (grant),
    .winner (winner)
  );

  assign grant_any = |grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_RUN;
      ptr          <= '0;
      credits      <= CREDITS_MAX;
      settle       <= '0;
      inject_q     <= '0;
      newcomm_q    <= '0;
      cfg_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      inject_q    <= grant_any ? (flits[winner] | FLIT_VALID_MASK) : '0;
      cfg_ready_q <= 1'b0;

      if (grant_any) begin
        ptr <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
      end

      // Grant and return in the same cycle cancel out.
      case ({grant_any, bus.credit_return})
        2'b10: credits <= credits - CNT_W'(1);
        2'b01: begin
          if (credits == CREDITS_MAX) credit_err_q <= 1'b1;
          else                        credits      <= credits + CNT_W'(1);
        end
        default: ;
      endcase

      case (state)
        ST_RUN: begin
          if (bus.cfg_valid) begin
            state  <= ST_DRAIN;
            busy_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (credits == CREDITS_MAX) begin
            state       <= ST_CONFIG;
            cfg_ready_q <= 1'b1;
          end
        end
        ST_CONFIG: begin
          newcomm_q <= bus.cfg_data;
          if (CFG_SETTLE == 0) begin
            state  <= ST_RUN;
            busy_q <= 1'b0;
          end else begin
            state  <= ST_SETTLE;
            settle <= SETTLE_W'(CFG_SETTLE);
          end
        end
        ST_SETTLE: begin
          settle <= settle - SETTLE_W'(1);
          if (settle <= SETTLE_W'(1)) begin
            state  <= ST_RUN;
            busy_q <= 1'b0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.req_ready   = grant;
  assign bus.inject_flit = inject_q;
  assign bus.cfg_ready   = cfg_ready_q;
  assign bus.newcomm_out = newcomm_q;
  assign bus.busy        = busy_q;
  assign bus.credit_err  = credit_err_q;

endmodule

// File: tb/tb_inject_scheduler.sv
// Directed and randomized checks of inject_scheduler against a cycle-level reference model.
module tb_inject_scheduler;
  import inject_scheduler_pkg::*;

  localparam int N      = 4;
  localparam int CRED   = 4;
  localparam int SETTLE = 2;

  logic clk;
  logic rst;

  inject_scheduler_if #(.NUM_REQ(N)) bus ();

  inject_scheduler #(.NUM_REQ(N), .CREDITS(CRED), .CFG_SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  flit_t       flits [N];
  flit_t       vmask;
  logic [60:0] cfg_word;
  int          grant_log [$];
  bit          hs_seen;

  // reference model state: credits, rr pointer, install progress
  int          m_credits;
  int          m_ptr;
  bit          m_err;
  bit          m_drain;
  bit          m_config;
  int          m_settle;
  logic [60:0] m_newcomm;
  flit_t       m_inject;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic flit_t rand_flit();
    return flit_t'({$urandom(), $urandom(), $urandom()});
  endfunction

  function automatic bit running();
    return !m_drain && !m_config && (m_settle == 0);
  endfunction

  task automatic model_reset();
    m_credits = CRED;
    m_ptr     = 0;
    m_err     = 0;
    m_drain   = 0;
    m_config  = 0;
    m_settle  = 0;
    m_newcomm = '0;
    m_inject  = '0;
  endtask

  // One clock: drive at negedge, check ready, advance model at posedge, check registered outputs.
  task automatic cycle(input logic [N-1:0] rv, input bit cr, input bit cv);
    int          w;
    int          c;
    bit          full;
    logic [60:0] nc;
    bus.req_valid     = rv;
    bus.credit_return = cr;
    bus.cfg_valid     = cv;
    bus.cfg_data      = newcomm_t'(cfg_word);
    bus.req_flit      = {flits[3], flits[2], flits[1], flits[0]};
    #1;
    w = -1;
    if (running() && !cv && m_credits > 0) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && rv[2'((m_ptr + k) % N)]) w = (m_ptr + k) % N;
      end
    end
    check("req_ready", 128'(bus.req_ready), (w >= 0) ? (128'(1) << w) : 128'(0));
    if (cv && bus.cfg_ready) hs_seen = 1;
    if (w >= 0) grant_log.push_back(w);
    @(posedge clk);
    full     = (m_credits == CRED);
    m_inject = (w >= 0) ? (flits[w] | vmask) : '0;
    if (w >= 0) begin
      m_ptr    = (w + 1) % N;
      flits[w] = rand_flit();
    end
    if (m_config) begin
      m_config  = 0;
      m_newcomm = cfg_word;
      m_settle  = SETTLE;
    end else if (m_drain) begin
      if (full) begin
        m_drain  = 0;
        m_config = 1;
      end
    end else if (m_settle > 0) begin
      m_settle--;
    end else if (cv) begin
      m_drain = 1;
    end
    c = m_credits - ((w >= 0) ? 1 : 0) + (cr ? 1 : 0);
    if (c > CRED) begin
      c     = CRED;
      m_err = 1;
    end
    m_credits = c;
    @(negedge clk);
    nc = bus.newcomm_out;
    check("inject_flit", 128'(bus.inject_flit), 128'(m_inject));
    check("busy",        128'(bus.busy),        128'(!running()));
    check("cfg_ready",   128'(bus.cfg_ready),   128'(m_config));
    check("newcomm_out", 128'(nc),              128'(m_newcomm));
    check("credit_err",  128'(bus.credit_err),  128'(m_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [60:0] nc;
    nc = bus.newcomm_out;
    check({tag, "_inject"},    128'(bus.inject_flit), 128'(0));
    check({tag, "_req_ready"}, 128'(bus.req_ready),   128'(0));
    check({tag, "_cfg_ready"}, 128'(bus.cfg_ready),   128'(0));
    check({tag, "_newcomm"},   128'(nc),              128'(0));
    check({tag, "_busy"},      128'(bus.busy),        128'(0));
    check({tag, "_err"},       128'(bus.credit_err),  128'(0));
  endtask

  initial begin
    int  first;
    int  guard;
    bit  cfg_act;
    logic [N-1:0] rv;
    bit  cr;

    vmask = 85'(1) << 81;
    for (int i = 0; i < N; i++) flits[i] = rand_flit();
    cfg_word          = '0;
    rst               = 1'b1;
    bus.req_valid     = '1;
    bus.req_flit      = {flits[3], flits[2], flits[1], flits[0]};
    bus.credit_return = 1'b0;
    bus.cfg_valid     = 1'b0;
    bus.cfg_data      = '0;
    model_reset();

    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst           = 1'b0;
    bus.req_valid = '0;

    // Single requester exhausts credits, one return buys one more grant.
    grant_log.delete();
    for (int i = 0; i < 6; i++) cycle(4'b0001, 0, 0);
    cycle(4'b0001, 1, 0);
    cycle(4'b0001, 0, 0);
    cycle(4'b0001, 0, 0);
    check("single_grants", 128'(grant_log.size()), 128'(5));
    for (int i = 0; i < 4; i++) cycle(4'b0000, 1, 0);

    // All requesting with a credit back every cycle: strict rotation.
    grant_log.delete();
    for (int i = 0; i < 12; i++) cycle(4'b1111, 1, 0);
    check("fair_count", 128'(grant_log.size()), 128'(12));
    for (int i = 1; i < grant_log.size(); i++)
      check("rr_order", 128'(grant_log[i]), 128'((grant_log[i-1] + 1) % N));

    // Drain with three credits outstanding, then install.
    for (int i = 0; i < 3; i++) cycle(4'b0001, 0, 0);
    cfg_word = 61'h1A5;
    hs_seen  = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(4'b1111, (i == 3 || i == 5 || i == 7), 1);
      if (hs_seen) break;
    end
    check("drain_handshake", 128'(hs_seen), 128'(1));
    first = -1;
    for (int i = 0; i < 6; i++) begin
      grant_log.delete();
      cycle(4'b1111, (m_credits < CRED), 0);
      if (first < 0 && grant_log.size() > 0) first = i;
    end
    check("resume_latency", 128'(first), 128'(SETTLE));

    // Credit overflow is sticky.
    guard = 0;
    while (m_credits < CRED && guard < 20) begin
      cycle(4'b0000, 1, 0);
      guard++;
    end
    cycle(4'b0000, 1, 0);
    check("credit_err_set", 128'(bus.credit_err), 128'(1));
    for (int i = 0; i < 5; i++) cycle(4'b1111, 0, 0);
    for (int i = 0; i < 4; i++) cycle(4'b0000, 1, 0);

    // Randomized traffic with occasional installs.
    cfg_act = 0;
    hs_seen = 0;
    for (int i = 0; i < 400; i++) begin
      rv = N'($urandom());
      cr = (m_credits < CRED) && ($urandom_range(2) != 0);
      if (!cfg_act && $urandom_range(39) == 0) begin
        cfg_act  = 1;
        cfg_word = 61'({$urandom(), $urandom()});
      end
      cycle(rv, cr, cfg_act);
      if (hs_seen) begin
        cfg_act = 0;
        hs_seen = 0;
      end
    end
    guard = 0;
    while (cfg_act && guard < 40) begin
      cycle(4'b0000, (m_credits < CRED), 1);
      if (hs_seen) cfg_act = 0;
      guard++;
    end
    check("random_install_done", 128'(cfg_act), 128'(0));

    // Reset in the middle of a drain.
    guard = 0;
    while (m_credits < CRED && guard < 20) begin
      cycle(4'b0000, 1, 0);
      guard++;
    end
    cycle(4'b0001, 0, 0);
    cycle(4'b0001, 0, 0);
    cfg_word = 61'h7;
    cycle(4'b1111, 0, 1);
    cycle(4'b0000, 0, 1);
    check("pre_reset_busy", 128'(bus.busy), 128'(1));
    bus.req_valid = 4'b1111;
    bus.cfg_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    grant_log.delete();
    for (int i = 0; i < 5; i++) cycle(4'b1111, 0, 0);
    check("post_reset_grants", 128'(grant_log.size()), 128'(4));
    if (grant_log.size() > 0)
      check("post_reset_first", 128'(grant_log[0]), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inject_scheduler.md
Name: inject_scheduler

Overview:
- Shares one node injection port (the node's inject_xpos input) among NUM_REQ host-side requesters.
- Uses round-robin arbitration with credit-based flow control toward the node's injection buffer.
- Sequences communicator-table installs on the node's newcomm input: injection is quiesced, drained and held off around each install, so no flit is in flight while the comm table changes.
- Sits between host collective engines and one node instance in the network top.

Parameters:
- NUM_REQ, 4, number of injection requesters (2..8).
- FLIT_CHILD_WIDTH, 85, flit plus children field width (82-bit flit + 3 child bits).
- VALID_BIT_POS, 81, flit valid bit index.
- NEW_COMM_WIDTH, 61, newcomm word width (53-bit comm table + 8-bit context id).
- CREDITS, 4, node injection buffer depth (1..15).
- CFG_SETTLE, 2, idle cycles after an install before injection resumes (0..7).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester flit available.
- req_flit  in  NUM_REQ*FLIT_CHILD_WIDTH  packed flits; requester i occupies slice i.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- inject_flit  out  FLIT_CHILD_WIDTH  to node inject_xpos.
- credit_return  in  1  one pulse per injection-buffer slot freed by the node.
- cfg_valid  in  1  install request.
- cfg_data  in  NEW_COMM_WIDTH  comm-table word; held stable while cfg_valid is high.
- cfg_ready  out  1  install accepted.
- newcomm_out  out  NEW_COMM_WIDTH  to node newcomm (level).
- busy  out  1  high whenever state is not RUN.
- credit_err  out  1  sticky; set on a credit return with the counter already full.

Behaviour:
- Reset (async, rst=1):
  - inject_flit=0, req_ready=0, cfg_ready=0, newcomm_out=0, busy=0, credit_err=0.
  - Credit counter=CREDITS, round-robin pointer=0, settle counter=0, state=RUN.
- Reset mid-operation: everything returns to the reset values immediately. The node shares rst, so no credits are outstanding afterwards.
- States: RUN, DRAIN, CONFIG, SETTLE.
- RUN:
  - Grant condition: cfg_valid=0, credit counter >0 and any req_valid.
  - When granting, req_ready is combinational one-hot to the first requesting index at or after the pointer, wrapping modulo NUM_REQ.
  - After a grant, pointer = winner+1 (mod NUM_REQ). With no grant, pointer is unchanged.
  - Next cycle after a grant: inject_flit = granted flit with bit VALID_BIT_POS forced to 1. Latency is 1 cycle.
  - Cycles without a grant: inject_flit = 0. Each flit is presented for exactly one cycle; back-to-back grants are allowed.
  - If cfg_valid=1: no grant this cycle, next state DRAIN. Config has priority over same-cycle requests.
- Credits:
  - A grant decrements the counter; a credit_return pulse increments it.
  - Grant and return in the same cycle: counter unchanged.
  - Return with counter==CREDITS and no same-cycle grant: counter stays at CREDITS and credit_err is set. credit_err clears only on reset.
  - Counter is never below 0, because a grant requires a nonzero counter.
- DRAIN:
  - No grants; inject_flit=0.
  - When the credit counter==CREDITS, go to CONFIG. This can happen on the first DRAIN cycle if nothing is outstanding.
- CONFIG (exactly 1 cycle):
  - cfg_ready=1; newcomm_out <= cfg_data, then held until the next install.
  - Next state SETTLE, settle counter loaded with CFG_SETTLE.
- SETTLE:
  - No grants; the settle counter decrements each cycle.
  - When it reaches 0, go to RUN.
  - CFG_SETTLE=0: go to RUN on the cycle after CONFIG.
- A new cfg_valid arriving in SETTLE is honoured only after reaching RUN, where it is seen on the first RUN cycle.
- busy=1 in DRAIN, CONFIG and SETTLE.
- Requester flit valid bits are ignored; only req_valid qualifies a request.
- req_flit[i] must stay stable while req_valid[i]=1 and ready is low. The scheduler does not check this.

Decomposition:
- Shared package, localparams: FLIT_CHILD_WIDTH, VALID_BIT_POS, NEW_COMM_WIDTH, lg_numprocs, DstWidth, CommTableWidth, ContextIdWidth, and the state encoding.
- One sub-module: rr_arbiter. Inputs: request vector, pointer, enable. Outputs: one-hot grant, winner index.
- Credit counter and FSM stay in inject_scheduler.

Test Plan:
- Single requester: req_valid=4'b0001 continuous, no credit_return → 4 grants in consecutive cycles, inject_flit valid bit=1 on cycles 1–4, then req_ready=0. One credit_return pulse → exactly one further grant.
- Fairness: all 4 valid, credit_return every cycle → grant order 0,1,2,3,0,…, one inject_flit per cycle.
- Drain: 3 credits outstanding, assert cfg_valid=1 with cfg_data=61'h1A5 → no grants and busy=1. After the 3rd credit_return, cfg_ready pulses one cycle and newcomm_out=61'h1A5. RUN resumes CFG_SETTLE=2 cycles later.
- Simultaneous events: cfg_valid and req_valid=4'b1111 together in RUN → no grant that cycle. Same-cycle grant + credit_return → counter unchanged.
- Credit overflow: counter full, credit_return pulse → credit_err=1, counter stays 4; credit_err stays 1 until rst.
- Reset mid-DRAIN: rst asserted → immediately inject_flit=0, cfg_ready=0, busy=0, newcomm_out=0. After release, the first grant goes to requester 0 with 4 credits available.
